// File: rtl/bin_to_therm_seq_ctrl.sv
// bin_to_therm_seq_ctrl: paced update controller for a segmented
// binary-to-thermometer DAC. Buffers codes in a small FIFO, releases one per
// programmable period and drives registered thermometer codes per segment.
// Optional data-weighted averaging on the low segment: BIN_TO_THERM_DWA_EN.
module bin_to_therm_seq_ctrl #(
  parameter  int N          = 10,
  parameter  int FIFO_DEPTH = 4,
  parameter  int DIV_W      = 8,
  localparam int H          = N / 2,
  localparam int M          = (1 << H) - 1,
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_data,
  output logic [M-1:0]     therm_high,
  output logic [M-1:0]     therm_low,
  output logic             update_strobe,
  output logic             underflow,
  output logic [LW-1:0]    fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [N-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [M-1:0]     r_therm_high, r_therm_low;
  logic             r_strobe, r_underflow;

  logic             w_empty, w_tick, w_push, w_pop, w_load_cnt;
  logic [N-1:0]     w_pop_data;
  logic [H-1:0]     w_hi, w_lo;
  logic [M-1:0]     w_therm_low;

  function automatic logic [M-1:0] f_therm(input logic [H-1:0] v);
    logic [M-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < M; i++) t[i] = (i < 32'(v));
    return t;
  endfunction

  assign w_empty    = (r_level == '0);
  assign s_ready    = (r_level < LW'(FIFO_DEPTH)) && !flush;
  assign w_push     = s_valid && s_ready;
  assign w_tick     = (r_state != IDLE) && (r_cnt == '0);
  assign w_pop      = w_tick && !w_empty && !flush;
  assign w_pop_data = r_mem[r_rd_ptr];
  assign w_hi       = w_pop_data[N-1:H];
  assign w_lo       = w_pop_data[H-1:0];

`ifdef BIN_TO_THERM_DWA_EN
  logic [H-1:0] r_ptr, w_ptr_nxt;
  logic [H:0]   w_ptr_sum;

  // Rotated thermometer for the low segment, starting at the DWA pointer
  always_comb begin
    int unsigned d;
    w_therm_low = '0;
    for (int unsigned j = 0; j < M; j++) begin
      d = j + M - 32'(r_ptr);
      if (d >= M) d = d - M;
      w_therm_low[j] = (d < 32'(w_lo));
    end
  end

  assign w_ptr_sum = {1'b0, r_ptr} + {1'b0, w_lo};
  assign w_ptr_nxt = (w_ptr_sum >= (H+1)'(M)) ? H'(w_ptr_sum - (H+1)'(M))
                                              : H'(w_ptr_sum);

  // DWA pointer advances by the low field on every update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (flush) r_ptr <= '0;
    else if (w_pop) r_ptr <= w_ptr_nxt;
  end
`else
  assign w_therm_low = f_therm(w_lo);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; disable and flush override, but a tick in the
  // disabling cycle still pops via w_pop
  always_comb begin
    w_state_nxt = r_state;
    w_load_cnt  = 1'b0;
    case (r_state)
      IDLE: if (en && !w_empty) begin
        w_state_nxt = RUN;
        w_load_cnt  = 1'b1;
      end
      RUN:  if (w_tick && w_empty)  w_state_nxt = HOLD;
      HOLD: if (w_tick && !w_empty) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (!en || flush) w_state_nxt = IDLE;
  end

  // Update-period counter: reloads on entry and on every tick, parked in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (flush)                r_cnt <= '0;
    else if (w_load_cnt || w_tick) r_cnt <= div_val;
    else if (r_state != IDLE)      r_cnt <= r_cnt - 1'b1;
  end

  // FIFO storage; emptiness is tracked by pointers so no reset needed here
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered DAC outputs and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_therm_high <= '0;
      r_therm_low  <= '0;
      r_strobe     <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (flush) begin
      r_therm_high <= '0;
      r_therm_low  <= '0;
      r_strobe     <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_therm_high <= f_therm(w_hi);
        r_therm_low  <= w_therm_low;
      end
      r_strobe    <= w_pop;
      r_underflow <= w_tick && w_empty;
    end
  end

  assign therm_high    = r_therm_high;
  assign therm_low     = r_therm_low;
  assign update_strobe = r_strobe;
  assign underflow     = r_underflow;
  assign fifo_level    = r_level;

endmodule

// File: doc/bin_to_therm_seq_ctrl.md
Name: bin_to_therm_seq_ctrl

Overview:
- Update controller for the segmented binary-to-thermometer DAC path.
- Accepts N-bit DAC codes over a valid/ready stream and buffers them in a small FIFO.
- Releases one code per programmable update period, splits it into high and low fields, and drives registered thermometer codes for both segments.
- Handles enable, flush, and underflow without glitching the DAC outputs.

Parameters:
- N, 10: total code width; must be even; H=N/2 bits per segment; M=2**H-1 thermometer bits per segment.
- FIFO_DEPTH, 4: sample buffer depth; must be a power of 2 and at least 2.
- DIV_W, 8: width of the update-period divider.

Ports:
- clk  in  1  system clock; all logic is on the posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- div_val  in  DIV_W  update period = div_val+1 cycles; sampled at each counter reload.
- flush  in  1  synchronous clear of the FIFO and outputs; highest priority.
- s_valid  in  1  input sample valid.
- s_ready  out  1  FIFO can accept a sample.
- s_data  in  N  binary code; high field = [N-1:H], low field = [H-1:0].
- therm_high  out  M  high-segment thermometer code.
- therm_low  out  M  low-segment thermometer code.
- update_strobe  out  1  one-cycle pulse, coincident with new output values.
- underflow  out  1  one-cycle pulse: update tick occurred with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n=0): asynchronous; state=IDLE, FIFO empty, fifo_level=0, therm_*=0, strobes=0, counter=0. s_ready=1 once reset releases. Mid-run reset discards everything.
- FIFO:
  - push on s_valid&&s_ready.
  - s_ready = (fifo_level<FIFO_DEPTH) && !flush; when full, a push is refused even if a pop occurs in the same cycle.
  - pop happens only on an update tick.
  - a push and a pop in the same cycle leave the level unchanged.
- Thermometer rule: bit i = 1 iff i < field. Field 0 gives all zeros; field M gives all ones.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: counter parked, no pops, outputs hold their last value. Go to RUN when en=1 and fifo_level>0; counter loads div_val on entry.
  - RUN:
    - counter decrements each cycle; tick when counter==0, then reload div_val.
    - on a tick with the FIFO non-empty: pop; therm_* register the new code on the next edge; update_strobe=1 in that same cycle.
    - first update is visible div_val+1 cycles after entering RUN.
    - on a tick with the FIFO empty: underflow pulses (same timing as update_strobe), outputs hold, go to HOLD.
  - HOLD:
    - counter keeps running so updates stay on the original grid.
    - on a tick with the FIFO non-empty: update as in RUN and return to RUN.
    - on a tick with the FIFO still empty: underflow pulses again.
  - From any state, en=0 goes to IDLE on the next cycle. A tick in that same cycle is honoured.
- flush:
  - FIFO cleared in one cycle; therm_*=0 on the next edge; state=IDLE; no strobes.
  - a push presented in the flush cycle is dropped.
- div_val change takes effect at the next reload only. div_val=0 gives an update every cycle.
- No combinational path from s_data to therm_*.

Optional Feature:
- Macro: BIN_TO_THERM_DWA_EN.
- Defined:
  - low segment uses data-weighted averaging with pointer ptr (H bits, range 0..M-1).
  - therm_low[j] = 1 iff ((j-ptr) mod M) < low field.
  - each update sets ptr = (ptr+low field) mod M.
  - ptr is cleared by reset and flush and held otherwise.
  - therm_high is unaffected.
- Undefined: plain thermometer on both segments; no pointer logic.

Test Plan:
- Reset mid-RUN with 2 samples queued -> therm_*=0, fifo_level=0, s_ready=1, state IDLE; no strobe after release.
- div_val=3, push 0x3FF then 0x000, en=1 -> first update_strobe 4 cycles after RUN entry with therm_high=therm_low=0x7FFFFFFF; next strobe exactly 4 cycles later with both 0; no further strobes except underflow pulses every 4 cycles.
- Push 0x125 (high=9, low=5), div_val=0 -> therm_high=0x000001FF, therm_low=0x0000001F (DWA off).
- en=0, push 5 samples back-to-back -> 4 accepted, s_ready=0, fifo_level=4; fifth held until en=1 and the first pop.
- div_val=1, single sample -> strobe at tick 1, underflow at tick 2 with outputs held; push 0x000 between ticks -> update at tick 3 on the 2-cycle grid, state RUN.
- BIN_TO_THERM_DWA_EN defined, low fields 5,5,25 -> therm_low 0x0000001F, 0x000003E0, 0x7FFFFC0F; ptr ends at 4; flush -> ptr=0, outputs 0.
